muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (RV32M op set): one radix-2 step per cycle on
// operand magnitudes, with the sign fix-up applied on the way into DONE.
module muldiv_unit #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int                CW     = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0]   ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]     ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     LAST_C = CW'(XLEN - 1);
    localparam logic              FAST   = (FAST_SPECIAL != 0);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   opnd_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic [XLEN-1:0]   spec_val_r;
    logic [XLEN-1:0]   result_r;
    logic              neg_r;
    logic              spec_r;
    logic              busy_r;
    logic              done_r;

    logic              is_div_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic              res_neg_s;
    logic              div0_s;
    logic              ovf_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN-1:0]   spec_val_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_diff_s;
    logic [XLEN-1:0]   nxt_hi_s;
    logic [XLEN-1:0]   nxt_lo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   div_val_s;
    logic [XLEN-1:0]   div_fix_s;
    logic [XLEN-1:0]   final_s;
    logic              last_s;

    // Decode signedness, operand magnitudes and the divide special cases
    always_comb begin
        is_div_s = funct3[2];
        a_neg_s  = 1'b0;
        b_neg_s  = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_neg_s = srcA[XLEN-1];
                b_neg_s = srcB[XLEN-1];
            end
            3'b010: begin
                a_neg_s = srcA[XLEN-1];
                b_neg_s = 1'b0;
            end
            default: begin
                a_neg_s = 1'b0;
                b_neg_s = 1'b0;
            end
        endcase
        if (a_neg_s) a_mag_s = ~srcA + ONE_X;
        else         a_mag_s = srcA;
        if (b_neg_s) b_mag_s = ~srcB + ONE_X;
        else         b_mag_s = srcB;
        // Remainder takes the dividend's sign; everything else the product of signs
        res_neg_s = (funct3[2] && funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
        div0_s    = is_div_s && (srcB == ZERO_X);
        ovf_s     = is_div_s && !funct3[0] && (srcA == MIN_X) && (srcB == ONES_X);
        if (div0_s)     spec_val_s = funct3[1] ? srcA : ONES_X;
        else if (ovf_s) spec_val_s = funct3[1] ? ZERO_X : srcA;
        else            spec_val_s = ZERO_X;
    end

    // One radix-2 step plus the signed final result that the step would produce
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_diff_s  = div_shift_s[XLEN-1:0] - opnd_r;
        if (op_r[2]) begin
            if (div_ge_s) begin
                nxt_hi_s = div_diff_s;
                nxt_lo_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi_s = div_shift_s[XLEN-1:0];
                nxt_lo_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            nxt_hi_s = mul_sum_s[XLEN:1];
            nxt_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
        prod_s     = {nxt_hi_s, nxt_lo_s};
        prod_fix_s = neg_r ? (~prod_s + ONE_2X) : prod_s;
        div_val_s  = op_r[1] ? nxt_hi_s : nxt_lo_s;
        div_fix_s  = neg_r ? (~div_val_s + ONE_X) : div_val_s;
        if (spec_r)                  final_s = spec_val_r;
        else if (op_r[2])            final_s = div_fix_s;
        else if (op_r[1:0] == 2'b00) final_s = prod_fix_s[XLEN-1:0];
        else                         final_s = prod_fix_s[2*XLEN-1:XLEN];
        last_s = (cnt_r == LAST_C) || (FAST && spec_r);
    end

    // Control FSM with iterative datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= ZERO_C;
            op_r       <= 3'b000;
            opnd_r     <= ZERO_X;
            hi_r       <= ZERO_X;
            lo_r       <= ZERO_X;
            spec_val_r <= ZERO_X;
            neg_r      <= 1'b0;
            spec_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= ZERO_X;
        end else if (flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= CALC;
                        busy_r     <= 1'b1;
                        cnt_r      <= ZERO_C;
                        op_r       <= funct3;
                        opnd_r     <= is_div_s ? b_mag_s : a_mag_s;
                        lo_r       <= is_div_s ? a_mag_s : b_mag_s;
                        hi_r       <= ZERO_X;
                        neg_r      <= res_neg_s;
                        spec_r     <= div0_s || ovf_s;
                        spec_val_r <= spec_val_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CALC: begin
                    hi_r  <= nxt_hi_s;
                    lo_r  <= nxt_lo_s;
                    cnt_r <= cnt_r + ONE_C;
                    if (last_s) begin
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= final_s;
                    end else begin
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule
